// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus between the IF stage and its memory port.
// master = fetch unit (drives req/addr); slave = memory (drives ack/data).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over req/ack, buffers one early instruction, feeds ID; IF_PERF_CNT_EN adds stall/drop counters.
// Latency: ack in cycle n -> inst_id valid after edge n+1 (1 inst/cycle with zero-wait memory).
// Backpressure: if_en=0 holds ID; a returning instruction parks in the 1-entry buffer and req drops until ID takes it.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_rst,
  input  logic                 if_en,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  if_fetch_unit_if.master      imem,
  output logic [31:0]          inst_id,
  output logic [31:0]          pc_id,
  output logic                 valid_id,
  output logic                 fetch_stall
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;
  logic [31:0] buf_dat, buf_dat_nxt;
  logic [31:0] inst_nxt, pc_nxt;
  logic        valid_nxt;
  logic        stall_raw;
  logic        drop;
  logic        in_rst;
  logic        ack;

  assign in_rst         = !rst || if_rst;
  assign imem.imem_req  = !in_rst && (state != S_FULL);
  assign imem.imem_addr = fetch_pc;
  // An ack is only meaningful against a live request; late acks after an abort fall here.
  assign ack            = imem.imem_ack && imem.imem_req;
  assign fetch_stall    = stall_raw && !in_rst;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    redir_pc_nxt = redir_pc;
    buf_dat_nxt  = buf_dat;
    inst_nxt     = inst_id;
    pc_nxt       = pc_id;
    valid_nxt    = valid_id;
    stall_raw    = 1'b0;
    drop         = 1'b0;

    if (redirect) begin
      inst_nxt  = NOP_INST;
      valid_nxt = 1'b0;
      unique case (state)
        S_FETCH: begin
          if (ack) begin
            fetch_pc_nxt = redirect_pc;
            drop         = 1'b1;
          end else begin
            redir_pc_nxt = redirect_pc;
            state_nxt    = S_DROP;
          end
        end
        S_FULL: begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = S_FETCH;
        end
        S_DROP: begin
          if (ack) begin
            fetch_pc_nxt = redirect_pc;
            state_nxt    = S_FETCH;
            drop         = 1'b1;
          end else begin
            redir_pc_nxt = redirect_pc;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end else begin
      unique case (state)
        S_FETCH: begin
          if (ack) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            if (if_en) begin
              inst_nxt  = imem.imem_data;
              pc_nxt    = fetch_pc;
              valid_nxt = 1'b1;
            end else begin
              buf_dat_nxt = imem.imem_data;
              state_nxt   = S_FULL;
            end
          end else if (if_en) begin
            inst_nxt  = NOP_INST;
            valid_nxt = 1'b0;
            stall_raw = 1'b1;
          end
        end
        S_FULL: begin
          // fetch_pc was already advanced past the buffered word, so its PC is fetch_pc-4.
          if (if_en) begin
            inst_nxt  = buf_dat;
            pc_nxt    = fetch_pc - 32'd4;
            valid_nxt = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_DROP: begin
          if (ack) begin
            fetch_pc_nxt = redir_pc;
            state_nxt    = S_FETCH;
            drop         = 1'b1;
          end
          if (if_en) begin
            inst_nxt  = NOP_INST;
            valid_nxt = 1'b0;
            stall_raw = 1'b1;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      redir_pc <= RESET_PC;
      buf_dat  <= NOP_INST;
      inst_id  <= NOP_INST;
      pc_id    <= RESET_PC;
      valid_id <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      redir_pc <= redir_pc_nxt;
      buf_dat  <= buf_dat_nxt;
      inst_id  <= inst_nxt;
      pc_id    <= pc_nxt;
      valid_id <= valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (in_rst) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (fetch_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (drop && (perf_drop_cnt != 32'hFFFF_FFFF))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
